issue_replay_buffer: RTL and testbench
======================================

ISSUE_REPLAY_BUFFER -- requirements
Module: issue_replay_buffer

Interface
REQ-001 Parameter DEPTH, default 8, buffer entries; power of two, at least 4.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 if_valid  in  3  fetch slot valid; contiguous from bit 0 (3'b000, 001, 011, 111 only).
REQ-005 if_inst_0..2  in  32 each  fetched instruction words, slot 0 oldest.
REQ-006 if_pc_0..2  in  32 each  PCs of fetched instructions.
REQ-007 if_ready  out  1  buffer accepts an enqueue this cycle.
REQ-008 id_inst_0..2  out  32 each  the three oldest entries presented to decode/hazard detection.
REQ-009 id_pc_0..2  out  32 each  PCs of the presented entries.
REQ-010 id_valid  out  3  presented-slot valid, contiguous from bit 0.
REQ-011 rollback  in  2  hazard-detector rollback: count of youngest presented slots returned (0..3).
REQ-012 stall  in  1  downstream stall; nothing is consumed.
REQ-013 flush  in  1  branch recovery; discards every entry.
REQ-014 count  out  4  current occupancy (0..DEPTH).

Function
REQ-015 Storage is a circular buffer with head (oldest) and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 id_* is combinational from storage: slot k shows entry head+k, and id_valid[k]=1 iff k<count; an invalid slot drives inst 32'h0 and pc 0.
REQ-017 if_ready=1 iff DEPTH-count>=3, evaluated on pre-update count; fetch holds if_* while if_ready=0.
REQ-018 Enqueue: when if_ready and not flush, the valid if slots are written at tail, tail+1, tail+2 in slot order, and tail advances by popcount(if_valid).
REQ-019 Consume count C = number of set id_valid bits with index < 3-rollback; C=0 when stall=1 or rollback=3.
REQ-020 Examples: id_valid=111, rollback=1 -> C=2; id_valid=001, rollback=2 -> C=1; id_valid=011, rollback=2 -> C=1.
REQ-021 Head advances by C at the clock edge; returned entries stay in place and are presented again in slots 0.. on the next cycle, with no reordering.
REQ-022 count_next = count + popcount(enqueued) - C; simultaneous enqueue and consume in one cycle is legal, with zero-cycle enqueue-to-present latency excluded (a new entry is visible on id_* one cycle after its enqueue edge).
REQ-023 Flush has priority: head, tail and count all go to 0 at the edge, and any same-cycle enqueue and consume are ignored.
REQ-024 Empty buffer: id_valid=000, and rollback/stall have no effect.
REQ-025 Full buffer (count=DEPTH): if_ready=0 and dequeue proceeds normally.
REQ-026 Never overflow or underflow; count saturates at neither end, since REQ-017/019 make both impossible.

Reset
REQ-027 On reset assertion, asynchronously: head=0, tail=0, count=0, id_valid=000, if_ready=1 (for DEPTH>=3).
REQ-028 Reset mid-operation discards all entries, and stored inst/pc contents need not be cleared.
REQ-029 The first enqueue is accepted on the first posedge after reset deasserts.

Structure
REQ-030 The shared package holds the ISSUE_WIDTH=3 constant and the IB_ENTRY typedef {inst[31:0], pc[31:0]}.
REQ-031 One combinational sub-module, ib_consume_calc, maps (id_valid, rollback, stall) to C.
REQ-032 No other sub-modules; storage is a flop array of IB_ENTRY.

Verification
REQ-033 Reset, then enqueue 3 (PC 0,4,8) -> next cycle id_valid=111, id_pc=0/4/8, count=3.
REQ-034 Six entries PC 0..20, rollback=1 -> next cycle id_pc=8/12/16, count=4; then rollback=2 -> id_pc=12/16/20, count=3.
REQ-035 rollback=3 for 2 cycles with 3 entries -> id_* unchanged and count=3 throughout; stall=1 gives the same result.
REQ-036 DEPTH=8, pointers near 6: enqueue 3 with tail=6 -> writes entries 6,7,0; later presentation crosses the wrap in order.
REQ-037 Fill to 6, if_ready=0; consume 3 while enqueue is offered -> enqueue is rejected that cycle and accepted the next, with count 3 then 6.
REQ-038 flush with simultaneous enqueue and rollback=0 -> next cycle count=0, id_valid=000; reset asserted mid-stream gives the same result asynchronously.

Source files
------------

// File: rtl/issue_replay_buffer_pkg.sv
// Shared types for the issue replay buffer: issue width, entry layout and a
// small popcount helper used for pointer arithmetic.
package issue_replay_buffer_pkg;

  localparam int unsigned ISSUE_WIDTH = 3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } IB_ENTRY;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/ib_consume_calc.sv
// Maps presented-slot valids, rollback and stall to the number of entries
// actually consumed by decode this cycle.
module ib_consume_calc
  import issue_replay_buffer_pkg::*;
(
  input  logic [2:0] id_valid,
  input  logic [1:0] rollback,
  input  logic       stall,
  output logic [1:0] consume
);

  logic [2:0] keep_mask;

  // Rollback returns the youngest slots, so only indices below 3-rollback count.
  always_comb begin
    keep_mask = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      keep_mask[k] = (k + 32'(rollback)) < ISSUE_WIDTH;
    end
  end

  always_comb begin
    consume = '0;
    if (!stall) begin
      consume = popcount3(id_valid & keep_mask);
    end
  end

endmodule

// File: rtl/issue_replay_buffer.sv
// Circular instruction buffer between fetch and decode that presents its three
// oldest entries and lets the hazard detector hand back the youngest of them.
module issue_replay_buffer
  import issue_replay_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  if_valid,
  input  logic [31:0] if_inst_0,
  input  logic [31:0] if_inst_1,
  input  logic [31:0] if_inst_2,
  input  logic [31:0] if_pc_0,
  input  logic [31:0] if_pc_1,
  input  logic [31:0] if_pc_2,
  output logic        if_ready,
  output logic [31:0] id_inst_0,
  output logic [31:0] id_inst_1,
  output logic [31:0] id_inst_2,
  output logic [31:0] id_pc_0,
  output logic [31:0] id_pc_1,
  output logic [31:0] id_pc_2,
  output logic [2:0]  id_valid,
  input  logic [1:0]  rollback,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  IB_ENTRY        mem [DEPTH];
  IB_ENTRY        in_e  [ISSUE_WIDTH];
  IB_ENTRY        out_e [ISSUE_WIDTH];
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [CW-1:0]  cnt_q;
  logic           enq;
  logic [1:0]     enq_n;
  logic [1:0]     consume;

  assign in_e[0] = '{inst: if_inst_0, pc: if_pc_0};
  assign in_e[1] = '{inst: if_inst_1, pc: if_pc_1};
  assign in_e[2] = '{inst: if_inst_2, pc: if_pc_2};

  assign if_ready = (DEPTH - 32'(cnt_q)) >= 32'd3;
  assign enq      = if_ready && !flush;
  assign enq_n    = enq ? popcount3(if_valid) : 2'd0;
  assign count    = 4'(cnt_q);

  always_comb begin
    id_valid = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      id_valid[k] = k < 32'(cnt_q);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      out_e[k] = '0;
      if (k < 32'(cnt_q)) begin
        out_e[k] = mem[head_q + PW'(k)];
      end
    end
  end

  assign id_inst_0 = out_e[0].inst;
  assign id_inst_1 = out_e[1].inst;
  assign id_inst_2 = out_e[2].inst;
  assign id_pc_0   = out_e[0].pc;
  assign id_pc_1   = out_e[1].pc;
  assign id_pc_2   = out_e[2].pc;

  ib_consume_calc u_consume (
    .id_valid (id_valid),
    .rollback (rollback),
    .stall    (stall),
    .consume  (consume)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_q + PW'(consume);
      tail_q <= tail_q + PW'(enq_n);
      cnt_q  <= cnt_q + CW'(enq_n) - CW'(consume);
    end
  end

  // Payload storage is left uncleared on reset; valid-ness comes from the pointers.
  always_ff @(posedge clock) begin
    if (enq) begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        if (if_valid[k]) begin
          mem[tail_q + PW'(k)] <= in_e[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_replay_buffer.sv
// Directed table-driven bench for issue_replay_buffer (DEPTH=8).
module tb_issue_replay_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  if_valid;
  logic [31:0] if_inst_0, if_inst_1, if_inst_2;
  logic [31:0] if_pc_0, if_pc_1, if_pc_2;
  logic        if_ready;
  logic [31:0] id_inst_0, id_inst_1, id_inst_2;
  logic [31:0] id_pc_0, id_pc_1, id_pc_2;
  logic [2:0]  id_valid;
  logic [1:0]  rollback;
  logic        stall;
  logic        flush;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  issue_replay_buffer #(.DEPTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_inst_0 (if_inst_0),
    .if_inst_1 (if_inst_1),
    .if_inst_2 (if_inst_2),
    .if_pc_0   (if_pc_0),
    .if_pc_1   (if_pc_1),
    .if_pc_2   (if_pc_2),
    .if_ready  (if_ready),
    .id_inst_0 (id_inst_0),
    .id_inst_1 (id_inst_1),
    .id_inst_2 (id_inst_2),
    .id_pc_0   (id_pc_0),
    .id_pc_1   (id_pc_1),
    .id_pc_2   (id_pc_2),
    .id_valid  (id_valid),
    .rollback  (rollback),
    .stall     (stall),
    .flush     (flush),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  iv;
    logic [31:0] pcb;
    logic [1:0]  rb;
    logic        st;
    logic        fl;
    logic        rdy;
    logic [3:0]  cnt;
    logic [2:0]  vld;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] iv, input logic [31:0] pcb, input logic [1:0] rb,
                       input logic st, input logic fl);
    if_valid  = iv;
    if_pc_0   = pcb;
    if_pc_1   = pcb + 32'd4;
    if_pc_2   = pcb + 32'd8;
    if_inst_0 = ~(pcb);
    if_inst_1 = ~(pcb + 32'd4);
    if_inst_2 = ~(pcb + 32'd8);
    rollback  = rb;
    stall     = st;
    flush     = fl;
  endtask

  task automatic check_out(input int idx, input logic [3:0] cnt, input logic [2:0] vld,
                           input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    chk("count", idx, 32'(count), 32'(cnt));
    chk("id_valid", idx, 32'(id_valid), 32'(vld));
    chk("id_pc_0", idx, id_pc_0, vld[0] ? p0 : 32'h0);
    chk("id_pc_1", idx, id_pc_1, vld[1] ? p1 : 32'h0);
    chk("id_pc_2", idx, id_pc_2, vld[2] ? p2 : 32'h0);
    chk("id_inst_0", idx, id_inst_0, vld[0] ? ~p0 : 32'h0);
    chk("id_inst_1", idx, id_inst_1, vld[1] ? ~p1 : 32'h0);
    chk("id_inst_2", idx, id_inst_2, vld[2] ? ~p2 : 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //            iv      pcb  rb st fl rdy cnt vld     p0   p1   p2
    vecs[0]  = '{3'b111,   0, 0, 0, 0, 1, 3, 3'b111,   0,   4,   8};
    vecs[1]  = '{3'b111,  12, 0, 1, 0, 1, 6, 3'b111,   0,   4,   8};
    vecs[2]  = '{3'b000,   0, 1, 0, 0, 0, 4, 3'b111,   8,  12,  16};
    vecs[3]  = '{3'b000,   0, 2, 0, 0, 1, 3, 3'b111,  12,  16,  20};
    vecs[4]  = '{3'b000,   0, 3, 0, 0, 1, 3, 3'b111,  12,  16,  20};
    vecs[5]  = '{3'b000,   0, 3, 0, 0, 1, 3, 3'b111,  12,  16,  20};
    vecs[6]  = '{3'b000,   0, 0, 1, 0, 1, 3, 3'b111,  12,  16,  20};
    vecs[7]  = '{3'b111,  24, 0, 1, 0, 1, 6, 3'b111,  12,  16,  20};
    vecs[8]  = '{3'b111, 100, 0, 0, 0, 0, 3, 3'b111,  24,  28,  32};
    vecs[9]  = '{3'b111, 100, 0, 1, 0, 1, 6, 3'b111,  24,  28,  32};
    vecs[10] = '{3'b000,   0, 0, 0, 0, 0, 3, 3'b111, 100, 104, 108};
    vecs[11] = '{3'b000,   0, 0, 0, 0, 1, 0, 3'b000,   0,   0,   0};
    vecs[12] = '{3'b000,   0, 2, 0, 0, 1, 0, 3'b000,   0,   0,   0};
    vecs[13] = '{3'b001, 200, 0, 0, 0, 1, 1, 3'b001, 200,   0,   0};
    vecs[14] = '{3'b011, 204, 2, 0, 0, 1, 2, 3'b011, 204, 208,   0};
    vecs[15] = '{3'b000,   0, 2, 0, 0, 1, 1, 3'b001, 208,   0,   0};
    vecs[16] = '{3'b111, 300, 0, 0, 1, 1, 0, 3'b000,   0,   0,   0};
    vecs[17] = '{3'b111, 400, 0, 1, 0, 1, 3, 3'b111, 400, 404, 408};
    vecs[18] = '{3'b011, 412, 0, 1, 0, 1, 5, 3'b111, 400, 404, 408};
    vecs[19] = '{3'b111, 420, 0, 1, 0, 1, 8, 3'b111, 400, 404, 408};
    vecs[20] = '{3'b111, 900, 0, 0, 0, 0, 5, 3'b111, 412, 416, 420};
    vecs[21] = '{3'b000,   0, 1, 0, 0, 1, 3, 3'b111, 420, 424, 428};

    reset = 1'b1;
    drive(3'b000, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_count", -1, 32'(count), 0);
    chk("reset_id_valid", -1, 32'(id_valid), 0);
    chk("reset_if_ready", -1, 32'(if_ready), 1);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].iv, vecs[i].pcb, vecs[i].rb, vecs[i].st, vecs[i].fl);
      #1;
      chk("if_ready", i, 32'(if_ready), 32'(vecs[i].rdy));
      @(posedge clock);
      #1;
      check_out(i, vecs[i].cnt, vecs[i].vld, vecs[i].p0, vecs[i].p1, vecs[i].p2);
    end

    // Asynchronous reset mid-stream with three entries held, away from any edge.
    drive(3'b000, 0, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 100, 32'(count), 0);
    chk("async_rst_id_valid", 100, 32'(id_valid), 0);
    chk("async_rst_if_ready", 100, 32'(if_ready), 1);
    chk("async_rst_id_pc_0", 100, id_pc_0, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(3'b011, 500, 0, 1, 0);
    #1;
    chk("if_ready", 101, 32'(if_ready), 1);
    @(posedge clock);
    #1;
    check_out(101, 4'd2, 3'b011, 500, 504, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
